display_decoder_mux: RTL and testbench
======================================

# display_decoder_mux

Drives the four-digit multiplexed 7-segment display of the timer from BCD digits. It is the output-side counterpart of the keypad encoder: the encoder turns key presses into BCD, and this block turns BCD back into segment and anode patterns. Inputs are sampled once per scan frame so the display never tears. The block supports leading-zero blanking, flashing for the paused state, and an active-low enable.

## Interface
- SCAN_DIV, 4: clock cycles each digit stays selected; must be ≥ 2.
- BLINK_DIV, 16: clock cycles per flash half-period; must be ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- min_tens, min_ones, sec_tens, sec_ones  in  4 each  BCD digits to display.
- blank_lz  in  1  1 = blank the min_tens digit when it is 0.
- flash  in  1  1 = blink the whole display.
- enablen  in  1  active-low display enable.
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g.
- an  out  4  active-low anodes; an[0]=sec_ones, an[1]=sec_tens, an[2]=min_ones, an[3]=min_tens.
- dp  out  1  active-low decimal point, used as the min:sec separator.
- frame_sync  out  1  one-cycle pulse when the shadow registers load.

## Operation
- **Scan counter `sc`**
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On each wrap, digit index `idx` advances 0→1→2→3→0.
- **Shadow load**
  - In the cycle where `idx` wraps 3→0, the four digits and `blank_lz` are registered into shadow registers.
  - `frame_sync` is 1 in that same clock cycle (registered, visible the cycle after the edge).
- **Segment decode** (active-low, written g..a):
  - 0=1000000
  - 1=1111001
  - 2=0100100
  - 3=0110000
  - 4=0011001
  - 5=0010010
  - 6=0000010
  - 7=1111000
  - 8=0000000
  - 9=0010000
  - 10–15 = 0111111 (dash, g only)
- **Anodes:** `an` has exactly one bit low, at position `idx`. All four are high when any of these holds:
  - `enablen`=1
  - flash phase is active
  - `idx`=3 with shadow `blank_lz`=1 and shadow `min_tens`=0
- **Decimal point:** `dp`=0 only while `idx`=2 and that digit is visible; otherwise `dp`=1.
- **Blanked output:** whenever all anodes are off, `seg`=1111111.
- **Flash**
  - Blink counter counts 0..BLINK_DIV-1 continuously; `phase` toggles on each wrap.
  - Flash is active when `flash`=1 and `phase`=1.
  - While `flash`=0, `phase` is held at 0, so the display returns to visible on the next cycle after `flash` falls.
- **Counters never stall:** `enablen` and `flash` do not stop the scan or blink counters; scanning and shadow loading continue.
- **Reset** (synchronous, all at once):
  - `sc`=0, `idx`=0, blink counter=0, `phase`=0
  - shadow digits=0, shadow `blank_lz`=0
  - `seg`=1111111, `an`=1111, `dp`=1, `frame_sync`=0
- **Reset mid-frame:** aborts the scan, discards the shadow contents, and restarts at `idx`=0.

## Timing
- `seg`, `an`, `dp`, `frame_sync` are all registered and reflect `idx` and shadow state with 1 cycle latency.
- Digit period is SCAN_DIV cycles; frame period is 4·SCAN_DIV cycles.
- After reset release, `idx`=0 is first driven on cycle 1. The first shadow load happens at the first 3→0 wrap, 4·SCAN_DIV cycles after reset release.
  - Until then the display shows 00:00, with `an` active since `enablen`=0.
- Input changes take effect at the next frame boundary, from 1 to 4·SCAN_DIV cycles later. Changes between loads are never visible.
- `enablen` and `flash` are not shadowed; they affect the outputs 1 cycle after they change.
- If `reset` and a frame wrap occur in the same cycle, reset wins and no load occurs.

## Test plan
- **Reset values:** hold `reset` 3 cycles → `seg`=1111111, `an`=1111, `dp`=1, `frame_sync`=0 throughout.
- **Scan and decode:** digits 1,2,3,4 (min_tens..sec_ones), SCAN_DIV=4 → after the first `frame_sync`, `an` cycles 1110→1101→1011→0111, 4 cycles each.
  - `seg` follows 0011001, 0110000, 0100100, 1111001 for those four anodes.
  - `dp`=0 only during `an`=1011.
- **Invalid BCD / frame-boundary sampling:** `sec_ones`=12 → dash 0111111 on `an`=1110. Change `sec_ones` to 5 mid-frame → the old value is held until the next `frame_sync`, then 0010010 is shown.
- **Leading-zero blank:** `min_tens`=0, `blank_lz`=1 → `an` never equals 0111; `seg`=1111111 during that slot. With `blank_lz`=0 → digit shows 1000000.
- **Flash and enable:** `flash`=1, BLINK_DIV=16 → all anodes off for 16 cycles, on for 16, repeating. `enablen`=1 → `an`=1111, `dp`=1, `seg`=1111111 on the next cycle, and `frame_sync` keeps pulsing every 16 cycles.
- **Reset mid-frame:** assert `reset` at `idx`=2 → the next cycle shows reset values, and the next `frame_sync` occurs exactly 16 cycles after release.

Source files
------------

// File: rtl/display_decoder_mux.sv
// Scans four BCD digits onto a multiplexed 7-segment display, one digit per SCAN_DIV cycles.
// Inputs are shadowed once per frame; outputs are registered (1 cycle); no backpressure, counters never stall.
module display_decoder_mux #(
   parameter int SCAN_DIV  = 4,
   parameter int BLINK_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_ones,
   input  logic       blank_lz,
   input  logic       flash,
   input  logic       enablen,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp,
   output logic       frame_sync
);

   localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [SW-1:0] sc;
   logic [1:0]    idx;
   logic [BW-1:0] bc;
   logic          phase;
   logic [3:0]    sh_digit [4];
   logic          sh_blank_lz;

   logic          sc_wrap;
   logic          frame_wrap;
   logic          blink_wrap;
   logic [3:0]    cur_digit;
   logic          digit_off;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_nxt;
   logic          dp_nxt;

   assign sc_wrap    = (sc == SW'(SCAN_DIV - 1));
   assign frame_wrap = sc_wrap && (idx == 2'd3);
   assign blink_wrap = (bc == BW'(BLINK_DIV - 1));

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   // Shadow slot order matches anode order: slot 0 is sec_ones, slot 3 is min_tens.
   always_comb begin
      cur_digit = sh_digit[idx];
      digit_off = enablen || (flash && phase) ||
                  ((idx == 2'd3) && sh_blank_lz && (sh_digit[3] == 4'd0));
      an_nxt    = 4'hF;
      seg_nxt   = 7'h7F;
      dp_nxt    = 1'b1;
      if (!digit_off) begin
         an_nxt       = 4'hF;
         an_nxt[idx]  = 1'b0;
         seg_nxt      = decode(cur_digit);
         dp_nxt       = (idx != 2'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sc          <= '0;
         idx         <= 2'd0;
         bc          <= '0;
         phase       <= 1'b0;
         sh_digit[0] <= 4'd0;
         sh_digit[1] <= 4'd0;
         sh_digit[2] <= 4'd0;
         sh_digit[3] <= 4'd0;
         sh_blank_lz <= 1'b0;
         seg         <= 7'h7F;
         an          <= 4'hF;
         dp          <= 1'b1;
         frame_sync  <= 1'b0;
      end else begin
         sc <= sc_wrap ? '0 : sc + SW'(1);
         if (sc_wrap) begin
            idx <= idx + 2'd1;
         end
         bc <= blink_wrap ? '0 : bc + BW'(1);
         // Phase is pinned low while not flashing so the display reappears immediately.
         if (!flash) begin
            phase <= 1'b0;
         end else if (blink_wrap) begin
            phase <= ~phase;
         end
         if (frame_wrap) begin
            sh_digit[0] <= sec_ones;
            sh_digit[1] <= sec_tens;
            sh_digit[2] <= min_ones;
            sh_digit[3] <= min_tens;
            sh_blank_lz <= blank_lz;
         end
         frame_sync <= frame_wrap;
         seg        <= seg_nxt;
         an         <= an_nxt;
         dp         <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_display_decoder_mux.sv
// Directed bench for display_decoder_mux: cycle-count model checked every cycle plus literal spot checks.
module tb_display_decoder_mux;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       blank_lz, flash, enablen;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;
   logic       frame_sync;

   int total = 0;
   int bad   = 0;

   display_decoder_mux #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clk(clk), .reset(reset),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .blank_lz(blank_lz), .flash(flash), .enablen(enablen),
      .seg(seg), .an(an), .dp(dp), .frame_sync(frame_sync)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Segment table written straight from the digit shapes (g..a, active low).
   logic [6:0] seg_tab [16];
   initial begin
      seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
      seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
      seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0010000;
      for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
   end

   // Model: position in the frame follows from cycles elapsed since reset release.
   int         m_n = 0;
   logic [3:0] m_sh [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
   logic       m_blz = 1'b0;
   logic       m_phase = 1'b0;
   logic       m_vld = 1'b0;
   logic [6:0] e_seg;
   logic [3:0] e_an;
   logic       e_dp, e_fs;

   int   m_idx, m_sc;
   logic m_off, m_fs;
   assign m_idx = (m_n / SCAN_DIV) % 4;
   assign m_sc  = m_n % SCAN_DIV;
   assign m_off = enablen || (flash && m_phase) || (m_idx == 3 && m_blz && m_sh[3] == 4'd0);
   assign m_fs  = (m_sc == SCAN_DIV - 1) && (m_idx == 3);

   always @(posedge clk) begin
      m_vld <= 1'b1;
      if (reset) begin
         m_n     <= 0;
         m_sh    <= '{4'd0, 4'd0, 4'd0, 4'd0};
         m_blz   <= 1'b0;
         m_phase <= 1'b0;
         e_seg   <= 7'h7F;
         e_an    <= 4'hF;
         e_dp    <= 1'b1;
         e_fs    <= 1'b0;
      end else begin
         e_an  <= m_off ? 4'hF : ~(4'b0001 << m_idx);
         e_seg <= m_off ? 7'h7F : seg_tab[m_sh[m_idx]];
         e_dp  <= !(m_idx == 2 && !m_off);
         e_fs  <= m_fs;
         if (m_fs) begin
            m_sh  <= '{sec_ones, sec_tens, min_ones, min_tens};
            m_blz <= blank_lz;
         end
         if (!flash) m_phase <= 1'b0;
         else if (m_n % BLINK_DIV == BLINK_DIV - 1) m_phase <= !m_phase;
         m_n <= m_n + 1;
      end
   end

   always @(negedge clk) begin
      if (m_vld) begin
         chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
         chk("model_an", {28'd0, an}, {28'd0, e_an});
         chk("model_dp", {31'd0, dp}, {31'd0, e_dp});
         chk("model_fs", {31'd0, frame_sync}, {31'd0, e_fs});
      end
   end

   // Returns cycles until frame_sync is seen (0 if the budget expires).
   task automatic wait_fs(output int cyc);
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (frame_sync) begin
            cyc = i;
            break;
         end
      end
   endtask

   logic [3:0] lit_an  [4];
   logic [6:0] lit_seg [4];
   int cyc, cnt;

   initial begin
      reset = 1'b1; enablen = 1'b0; flash = 1'b0; blank_lz = 1'b0;
      min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
      lit_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      lit_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_seg", {25'd0, seg}, 32'h7F);
         chk("rst_an", {28'd0, an}, 32'hF);
         chk("rst_dp", {31'd0, dp}, 32'd1);
         chk("rst_fs", {31'd0, frame_sync}, 32'd0);
      end
      reset = 1'b0;

      wait_fs(cyc);
      chk("first_fs_cycles", cyc, 32'd16);
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("scan_an", {28'd0, an}, {28'd0, lit_an[d]});
            chk("scan_seg", {25'd0, seg}, {25'd0, lit_seg[d]});
            chk("scan_dp", {31'd0, dp}, (d == 2) ? 32'd0 : 32'd1);
         end
      end

      sec_ones = 4'd12;
      wait_fs(cyc);
      @(negedge clk);
      chk("dash_an", {28'd0, an}, 32'hE);
      chk("dash_seg", {25'd0, seg}, 32'h3F);
      repeat (5) @(negedge clk);
      sec_ones = 4'd5;
      wait_fs(cyc);
      chk("held_fs_cycles", cyc, 32'd10);
      @(negedge clk);
      chk("new5_seg", {25'd0, seg}, 32'h12);

      min_tens = 4'd0; blank_lz = 1'b1;
      wait_fs(cyc);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (an == 4'b0111) cnt++;
         if (i >= 12) chk("lz_seg", {25'd0, seg}, 32'h7F);
      end
      chk("lz_an_count", cnt, 32'd0);
      blank_lz = 1'b0;
      wait_fs(cyc);
      repeat (13) @(negedge clk);
      chk("nolz_an", {28'd0, an}, 32'h7);
      chk("nolz_seg", {25'd0, seg}, 32'h40);

      flash = 1'b1;
      repeat (20) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (an == 4'hF) cnt++;
      end
      chk("flash_off_count", cnt, 32'd32);
      flash = 1'b0;
      @(negedge clk);
      chk("flash_release_vis", {31'd0, an != 4'hF}, 32'd1);

      enablen = 1'b1;
      @(negedge clk);
      chk("dis_an", {28'd0, an}, 32'hF);
      chk("dis_seg", {25'd0, seg}, 32'h7F);
      chk("dis_dp", {31'd0, dp}, 32'd1);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (frame_sync) cnt++;
      end
      chk("dis_fs_count", cnt, 32'd4);
      enablen = 1'b0;

      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (an == 4'b1011) begin
            cnt = 1;
            break;
         end
      end
      chk("found_idx2", cnt, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_an", {28'd0, an}, 32'hF);
      chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
      chk("mid_rst_fs", {31'd0, frame_sync}, 32'd0);
      reset = 1'b0;
      wait_fs(cyc);
      chk("mid_rst_fs_cycles", cyc, 32'd16);
      @(negedge clk);
      chk("mid_rst_digit", {25'd0, seg}, {25'd0, seg_tab[5]});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
